sha_schedule: RTL and testbench

Message-schedule and round sequencer for the SHA datapath. It accepts one padded message block, then streams one schedule word W_t and round constant K_t per cycle, with a round-enable strobe, into the compression-round stage. Mode is selected per block: SHA-1, SHA-224/256 or SHA-384/512. It is the producing end of the w/k/enable side of the compression-round interface.

---
 rtl/sha.sv | 5 +
 rtl/sha_schedule.sv | 100 ++++++++++
 tb/tb_sha_schedule.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha.sv
// sha: shared word and mode types for the SHA datapath
package sha;
   typedef logic [63:0] word_t;
   typedef enum logic [2:0] {SHA1 = 3'd0, SHA224 = 3'd1, SHA256 = 3'd2, SHA384 = 3'd3, SHA512 = 3'd4} mode_t;
endpackage

// File: rtl/sha_schedule.sv
// sha_schedule: loads one padded block, then streams W_t/K_t with a round strobe for SHA-1, SHA-224/256 or SHA-384/512
module sha_schedule
   import sha::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  mode_t         mode,
   input  logic          blk_valid,
   output logic          blk_ready,
   input  logic [1023:0] blk_data,
   input  logic          hold,
   output logic          round_en,
   output word_t         w,
   output word_t         k,
   output logic [6:0]    round,
   output logic          last,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // SHA-256 constants are the upper halves of the first 64 SHA-512 constants
   localparam word_t K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
   state_t      r_state;
   mode_t       r_mode;
   word_t       r_win [16];
   logic [6:0]  r_t;
   logic        w_m1, w_m32, w_end;
   logic [31:0] w_a, w_b, w_x, w_s0_32, w_s1_32, w_k1;
   word_t       w_s0_64, w_s1_64, w_new;

   function automatic logic narrow(input mode_t m);
      return m == SHA1 || m == SHA224 || m == SHA256;
   endfunction

   assign w_m1    = r_mode == SHA1;
   assign w_m32   = narrow(r_mode);
   assign w_end   = r_t == ((w_m32 && !w_m1) ? 7'd63 : 7'd79);
   assign w_a     = r_win[1][31:0];
   assign w_b     = r_win[14][31:0];
   assign w_x     = r_win[13][31:0] ^ r_win[8][31:0] ^ r_win[2][31:0] ^ r_win[0][31:0];
   assign w_s0_32 = {w_a[6:0], w_a[31:7]} ^ {w_a[17:0], w_a[31:18]} ^ (w_a >> 3);
   assign w_s1_32 = {w_b[16:0], w_b[31:17]} ^ {w_b[18:0], w_b[31:19]} ^ (w_b >> 10);
   assign w_s0_64 = {r_win[1][0], r_win[1][63:1]} ^ {r_win[1][7:0], r_win[1][63:8]} ^ (r_win[1] >> 7);
   assign w_s1_64 = {r_win[14][18:0], r_win[14][63:19]} ^ {r_win[14][60:0], r_win[14][63:61]} ^ (r_win[14] >> 6);
   assign w_new   = w_m1  ? {32'd0, w_x[30:0], w_x[31]}
                  : w_m32 ? {32'd0, w_s1_32 + r_win[9][31:0] + w_s0_32 + r_win[0][31:0]}
                  : w_s1_64 + r_win[9] + w_s0_64 + r_win[0];
   assign w_k1    = r_t < 7'd20 ? 32'h5a827999 : r_t < 7'd40 ? 32'h6ed9eba1 : r_t < 7'd60 ? 32'h8f1bbcdc : 32'hca62c1d6;

   assign blk_ready = r_state == IDLE;
   assign round_en  = r_state == RUN && !hold;
   assign last      = round_en && w_end;
   assign done      = r_state == DONE;
   assign round     = r_t;
   assign w         = r_state == RUN ? r_win[0] : '0;
   assign k         = r_state != RUN ? '0 : w_m1 ? {32'd0, w_k1} : w_m32 ? {32'd0, K512[r_t][63:32]} : K512[r_t];

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_state <= IDLE;
         r_mode  <= SHA256;
         r_t     <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else
         case (r_state)
            IDLE: if (blk_valid) begin
               r_state <= RUN;
               r_mode  <= mode;
               r_t     <= '0;
               for (int i = 0; i < 16; i++)
                  r_win[i] <= narrow(mode) ? {32'd0, blk_data[991 - 64*i -: 32]} : blk_data[1023 - 64*i -: 64];
            end
            RUN: if (!hold) begin
               for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
               r_win[15] <= w_new;
               r_t       <= w_end ? '0 : r_t + 7'd1;
               if (w_end) r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
endmodule

// File: tb/tb_sha_schedule.sv
// tb_sha_schedule: randomized bench comparing sha_schedule against an array-based message-schedule model
module tb_sha_schedule;
   import sha::*;
   logic          clk = 0, rstn = 0, blk_valid = 0, hold = 0;
   mode_t         mode = SHA256;
   logic [1023:0] blk_data = '0;
   logic          blk_ready, round_en, last, done;
   word_t         w, k;
   logic [6:0]    round;
   int            checks = 0, failures = 0;

   sha_schedule dut (.clk(clk), .rstn(rstn), .mode(mode), .blk_valid(blk_valid), .blk_ready(blk_ready),
                     .blk_data(blk_data), .hold(hold), .round_en(round_en), .w(w), .k(k), .round(round),
                     .last(last), .done(done));

   always #5 clk = ~clk;

   bit            c_en [512], c_last [512], c_done [512], c_ready [512], hold_pat [512];
   word_t         c_w [512], c_k [512];
   logic [6:0]    c_r [512];
   mode_t         q_mode [$];
   logic [1023:0] q_data [$];
   bit            tog = 0;
   word_t         mw [80], ow [80], okk [80];
   int            orr [80];
   bit            olast [80];
   int            n_en, first_en, n_last, last_i, n_done, done_i;

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic word_t rotr64(input word_t x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction
   function automatic bit narrow(input mode_t m);
      return m != SHA384 && m != SHA512;
   endfunction
   function automatic int rounds(input mode_t m);
      return (m == SHA224 || m == SHA256) ? 64 : 80;
   endfunction
   function automatic logic [31:0] k_sha1(input int t);
      return t < 20 ? 32'h5a827999 : t < 40 ? 32'h6ed9eba1 : t < 60 ? 32'h8f1bbcdc : 32'hca62c1d6;
   endfunction
   function automatic logic [1023:0] pack(input word_t b [16]);
      logic [1023:0] d;
      for (int i = 0; i < 16; i++) d[1023 - 64*i -: 64] = b[i];
      return d;
   endfunction

   task automatic rand_blk(output word_t b [16]);
      for (int i = 0; i < 16; i++) b[i] = {$urandom, $urandom};
   endtask

   // Full schedule W[0..79] by the textbook recurrence over absolute indices
   task automatic build(input mode_t m, input word_t b [16]);
      logic [31:0] a, c;
      for (int t = 0; t < 16; t++) mw[t] = narrow(m) ? {32'd0, b[t][31:0]} : b[t];
      for (int t = 16; t < 80; t++) begin
         a = mw[t-15][31:0];
         c = mw[t-2][31:0];
         if (m == SHA1)
            mw[t] = {32'd0, rotr32(mw[t-3][31:0] ^ mw[t-8][31:0] ^ mw[t-14][31:0] ^ mw[t-16][31:0], 31)};
         else if (narrow(m))
            mw[t] = {32'd0, (rotr32(c, 17) ^ rotr32(c, 19) ^ (c >> 10)) + mw[t-7][31:0]
                          + (rotr32(a, 7) ^ rotr32(a, 18) ^ (a >> 3)) + mw[t-16][31:0]};
         else
            mw[t] = (rotr64(mw[t-2], 19) ^ rotr64(mw[t-2], 61) ^ (mw[t-2] >> 6)) + mw[t-7]
                  + (rotr64(mw[t-15], 1) ^ rotr64(mw[t-15], 8) ^ (mw[t-15] >> 7)) + mw[t-16];
      end
   endtask

   // Runs n cycles offering queued blocks back to back; index 0 is the cycle after the first edge
   task automatic collect(input int n);
      mode_t cur;
      bit    acc;
      cur = mode;
      if (q_mode.size() > 0) begin
         cur = q_mode.pop_front();
         mode = cur;
         blk_data = q_data.pop_front();
         blk_valid = 1;
      end
      acc = blk_ready && blk_valid;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (acc) begin
            if (q_mode.size() > 0) begin
               cur = q_mode.pop_front();
               blk_data = q_data.pop_front();
            end else blk_valid = 0;
         end
         hold = hold_pat[i];
         mode = (tog && !blk_ready) ? mode_t'(3'($urandom_range(0, 4))) : cur;
         #1;
         c_en[i] = round_en; c_w[i] = w; c_k[i] = k; c_r[i] = round;
         c_last[i] = last; c_done[i] = done; c_ready[i] = blk_ready;
         acc = blk_ready && blk_valid;
      end
      hold = 0;
   endtask

   task automatic scan(input int lo, input int hi);
      n_en = 0; first_en = -1; n_last = 0; last_i = -1; n_done = 0; done_i = -1;
      for (int i = lo; i <= hi; i++) begin
         if (c_en[i]) begin
            if (n_en < 80) begin
               ow[n_en] = c_w[i]; okk[n_en] = c_k[i]; orr[n_en] = int'(c_r[i]); olast[n_en] = c_last[i];
            end
            if (first_en < 0) first_en = i;
            n_en++;
         end
         if (c_last[i]) begin n_last++; last_i = i; end
         if (c_done[i]) begin n_done++; if (done_i < 0) done_i = i; end
      end
   endtask

   task automatic test_reset;
      rstn = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({blk_ready, round_en, last, done} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=1000", {blk_ready, round_en, last, done}); end
      checks++; if (w !== 64'd0 || k !== 64'd0 || round !== 7'd0) begin failures++; $display("FAIL reset_data w=%h k=%h round=%0d exp all 0", w, k, round); end
      @(negedge clk);
      rstn = 1;
      @(posedge clk);
      #2;
      checks++; if (blk_ready !== 1'b1 || round_en !== 1'b0) begin failures++; $display("FAIL reset_release ready=%b en=%b exp 1/0", blk_ready, round_en); end
   endtask

   task automatic test_sha256_abc;
      word_t b [16];
      b = '{default: 64'd0};
      b[0] = 64'h61626380; b[15] = 64'h18;
      build(SHA256, b);
      q_mode.push_back(SHA256); q_data.push_back(pack(b));
      collect(70);
      scan(0, 69);
      checks++; if (n_en !== 64 || first_en !== 0) begin failures++; $display("FAIL s256_rounds n=%0d first=%0d exp 64/0", n_en, first_en); end
      for (int t = 0; t < 64; t++) begin
         checks++; if (ow[t] !== mw[t] || orr[t] !== t) begin failures++; $display("FAIL s256_w t=%0d got=%h round=%0d exp=%h", t, ow[t], orr[t], mw[t]); end
         checks++; if (okk[t][63:32] !== 32'd0) begin failures++; $display("FAIL s256_kupper t=%0d got=%h exp 0", t, okk[t]); end
      end
      checks++; if (ow[0] !== 64'h61626380 || ow[16] !== 64'h61626380 || ow[17] !== 64'h000f0000) begin failures++; $display("FAIL s256_vec w0=%h w16=%h w17=%h", ow[0], ow[16], ow[17]); end
      checks++; if (okk[0] !== 64'h428a2f98 || okk[63] !== 64'hc67178f2) begin failures++; $display("FAIL s256_k k0=%h k63=%h", okk[0], okk[63]); end
      checks++; if (n_last !== 1 || !olast[63] || last_i !== 63) begin failures++; $display("FAIL s256_last n=%0d at=%0d exp 1/63", n_last, last_i); end
      checks++; if (n_done !== 1 || done_i !== 64) begin failures++; $display("FAIL s256_done n=%0d at=%0d exp 1/64", n_done, done_i); end
      checks++; if (c_ready[64] !== 1'b0 || c_ready[65] !== 1'b1) begin failures++; $display("FAIL s256_ready at64=%b at65=%b exp 0/1", c_ready[64], c_ready[65]); end
   endtask

   task automatic test_sha1_abc;
      word_t b [16];
      b = '{default: 64'd0};
      b[0] = 64'h61626380; b[15] = 64'h18;
      build(SHA1, b);
      q_mode.push_back(SHA1); q_data.push_back(pack(b));
      collect(84);
      scan(0, 83);
      checks++; if (n_en !== 80 || done_i !== 80 || n_done !== 1) begin failures++; $display("FAIL s1_rounds n=%0d done_at=%0d exp 80/80", n_en, done_i); end
      for (int t = 0; t < 80; t++) begin
         checks++; if (ow[t] !== mw[t] || okk[t] !== {32'd0, k_sha1(t)}) begin failures++; $display("FAIL s1_wk t=%0d w=%h k=%h exp w=%h k=%h", t, ow[t], okk[t], mw[t], k_sha1(t)); end
      end
      checks++; if (ow[16] !== 64'hc2c4c700) begin failures++; $display("FAIL s1_w16 got=%h exp=c2c4c700", ow[16]); end
      checks++; if (okk[19] !== 64'h5a827999 || okk[20] !== 64'h6ed9eba1) begin failures++; $display("FAIL s1_kswitch k19=%h k20=%h", okk[19], okk[20]); end
      checks++; if (!olast[79] || n_last !== 1) begin failures++; $display("FAIL s1_last n=%0d exp 1 at t79", n_last); end
   endtask

   task automatic test_sha512_abc;
      word_t b [16];
      b = '{default: 64'd0};
      b[0] = 64'h6162638000000000; b[15] = 64'h18;
      build(SHA512, b);
      q_mode.push_back(SHA512); q_data.push_back(pack(b));
      collect(84);
      scan(0, 83);
      checks++; if (n_en !== 80 || done_i !== 80) begin failures++; $display("FAIL s512_rounds n=%0d done_at=%0d exp 80/80", n_en, done_i); end
      for (int t = 0; t < 80; t++) begin
         checks++; if (ow[t] !== mw[t]) begin failures++; $display("FAIL s512_w t=%0d got=%h exp=%h", t, ow[t], mw[t]); end
      end
      checks++; if (ow[16] !== 64'h6162638000000000 || ow[0][63:32] !== 32'h61626380) begin failures++; $display("FAIL s512_vec w0=%h w16=%h", ow[0], ow[16]); end
      checks++; if (okk[0] !== 64'h428a2f98d728ae22 || okk[79] !== 64'h6c44198c4a475817) begin failures++; $display("FAIL s512_k k0=%h k79=%h", okk[0], okk[79]); end
   endtask

   task automatic test_hold;
      word_t b [16];
      rand_blk(b);
      build(SHA256, b);
      q_mode.push_back(SHA256); q_data.push_back(pack(b));
      for (int i = 20; i < 23; i++) hold_pat[i] = 1;
      collect(72);
      for (int i = 20; i < 23; i++) hold_pat[i] = 0;
      scan(0, 71);
      for (int i = 20; i < 23; i++) begin
         checks++; if (c_en[i] !== 1'b0 || c_r[i] !== 7'd20 || c_w[i] !== mw[20]) begin failures++; $display("FAIL hold_frozen cyc=%0d en=%b round=%0d w=%h exp 0/20/%h", i, c_en[i], c_r[i], c_w[i], mw[20]); end
      end
      checks++; if (n_en !== 64 || done_i !== 67) begin failures++; $display("FAIL hold_count n=%0d done_at=%0d exp 64/67", n_en, done_i); end
      for (int t = 0; t < 64; t++) begin
         checks++; if (ow[t] !== mw[t] || orr[t] !== t) begin failures++; $display("FAIL hold_w t=%0d got=%h exp=%h", t, ow[t], mw[t]); end
      end
   endtask

   task automatic test_back_to_back;
      word_t a [16], b [16];
      rand_blk(a);
      rand_blk(b);
      q_mode.push_back(SHA224); q_data.push_back(pack(a));
      q_mode.push_back(SHA384); q_data.push_back(pack(b));
      tog = 1;
      collect(152);
      tog = 0;
      build(SHA224, a);
      scan(0, 65);
      checks++; if (n_en !== 64 || done_i !== 64 || c_ready[65] !== 1'b1) begin failures++; $display("FAIL b2b_first n=%0d done_at=%0d ready65=%b exp 64/64/1", n_en, done_i, c_ready[65]); end
      for (int t = 0; t < 64; t++) begin
         checks++; if (ow[t] !== mw[t]) begin failures++; $display("FAIL b2b_w224 t=%0d got=%h exp=%h", t, ow[t], mw[t]); end
      end
      checks++; if (okk[0] !== 64'h428a2f98) begin failures++; $display("FAIL b2b_k224 got=%h exp=428a2f98", okk[0]); end
      build(SHA384, b);
      scan(66, 151);
      checks++; if (first_en !== 66 || n_en !== 80 || done_i !== 146) begin failures++; $display("FAIL b2b_second first=%0d n=%0d done_at=%0d exp 66/80/146", first_en, n_en, done_i); end
      for (int t = 0; t < 80; t++) begin
         checks++; if (ow[t] !== mw[t]) begin failures++; $display("FAIL b2b_w384 t=%0d got=%h exp=%h", t, ow[t], mw[t]); end
      end
      checks++; if (okk[79] !== 64'h6c44198c4a475817) begin failures++; $display("FAIL b2b_k384 got=%h", okk[79]); end
   endtask

   task automatic test_reset_midrun;
      word_t a [16], b [16];
      rand_blk(a);
      q_mode.push_back(SHA256); q_data.push_back(pack(a));
      collect(31);
      checks++; if (round !== 7'd30 || round_en !== 1'b1) begin failures++; $display("FAIL midrun_pre round=%0d en=%b exp 30/1", round, round_en); end
      rstn = 0;
      #1;
      checks++; if ({blk_ready, round_en, last, done} !== 4'b1000 || w !== 64'd0 || k !== 64'd0 || round !== 7'd0) begin failures++; $display("FAIL midrun_reset flags=%b w=%h k=%h round=%0d", {blk_ready, round_en, last, done}, w, k, round); end
      @(posedge clk);
      @(negedge clk);
      rstn = 1;
      collect(6);
      scan(0, 5);
      checks++; if (n_en !== 0 || n_done !== 0) begin failures++; $display("FAIL midrun_quiet en=%0d done=%0d exp 0/0", n_en, n_done); end
      rand_blk(b);
      build(SHA1, b);
      q_mode.push_back(SHA1); q_data.push_back(pack(b));
      collect(84);
      scan(0, 83);
      checks++; if (first_en !== 0 || n_en !== 80 || done_i !== 80) begin failures++; $display("FAIL midrun_fresh first=%0d n=%0d done_at=%0d exp 0/80/80", first_en, n_en, done_i); end
      for (int t = 0; t < 80; t++) begin
         checks++; if (ow[t] !== mw[t] || orr[t] !== t) begin failures++; $display("FAIL midrun_w t=%0d got=%h exp=%h", t, ow[t], mw[t]); end
      end
   endtask

   task automatic test_random;
      word_t b [16];
      mode_t m;
      int    n;
      for (int it = 0; it < 4; it++) begin
         m = mode_t'(3'($urandom_range(0, 4)));
         n = rounds(m);
         rand_blk(b);
         build(m, b);
         q_mode.push_back(m); q_data.push_back(pack(b));
         for (int i = 0; i < 230; i++) hold_pat[i] = ($urandom_range(0, 3) == 0);
         tog = 1;
         collect(230);
         tog = 0;
         for (int i = 0; i < 230; i++) hold_pat[i] = 0;
         scan(0, 229);
         checks++; if (n_en !== n || n_done !== 1 || done_i !== last_i + 1 || n_last !== 1) begin failures++; $display("FAIL rand_ctl it=%0d mode=%0d n=%0d done=%0d/%0d last_at=%0d", it, m, n_en, n_done, done_i, last_i); end
         checks++; if (!olast[n-1]) begin failures++; $display("FAIL rand_last it=%0d last not on t=%0d", it, n - 1); end
         for (int t = 0; t < n; t++) begin
            checks++; if (ow[t] !== mw[t] || orr[t] !== t) begin failures++; $display("FAIL rand_w it=%0d t=%0d got=%h exp=%h", it, t, ow[t], mw[t]); end
            checks++; if ((m == SHA1 && okk[t] !== {32'd0, k_sha1(t)}) || (narrow(m) && okk[t][63:32] !== 32'd0)) begin failures++; $display("FAIL rand_k it=%0d t=%0d got=%h", it, t, okk[t]); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_sha256_abc;
      test_sha1_abc;
      test_sha512_abc;
      test_hold;
      test_back_to_back;
      test_reset_midrun;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
